// File: rtl/jt49_boxcar_pkg.sv
// Shared JT49 filter-chain definitions: running-sum state encoding
// and accumulator width helper, reused by later filter stages.
package jt49_boxcar_pkg;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } box_st_t;

   // Exact width of a sum of 2**depth unsigned dw-bit samples
   function automatic int sum_w(input int dw, input int depth);
      return dw + depth;
   endfunction

endpackage

// File: rtl/jt49_boxcar.sv
// Boxcar (moving-average) stage fed by the JT49 long delay line.
// Ports: clk, rst (sync, active-high), cen (sample enable), clr (sync
// clear), din (current sample), dly (din delayed 2**depth cen ticks),
// dout (registered window average), valid (window has filled).
module jt49_boxcar
   import jt49_boxcar_pkg::*;
#(
   parameter int DW    = 8,
   parameter int depth = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          clr,
   input  logic [DW-1:0] din,
   input  logic [DW-1:0] dly,
   output logic [DW-1:0] dout,
   output logic          valid
);

   localparam int SW = sum_w(DW, depth);
   localparam logic [depth:0] LAST = {1'b0, {depth{1'b1}}};

   box_st_t           st;
   logic [depth:0]    cnt;
   logic [SW-1:0]     acc;
   logic [DW-1:0]     dly_m;
   logic signed [DW:0] diff;
   logic [SW-1:0]     acc_nxt;

   // Delay RAM is undefined until a full window has been written,
   // so the outgoing sample only counts once we are in RUN.
   assign dly_m = (st == RUN) ? dly : '0;
   assign diff  = $signed({1'b0, din}) - $signed({1'b0, dly_m});

   // Sign-extended add; the true sum is never negative, so the
   // modular result is exact.
   assign acc_nxt = acc + SW'(diff);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         st    <= FILL;
         cnt   <= '0;
         acc   <= '0;
         dout  <= '0;
         valid <= 1'b0;
      end else if (cen) begin
         // Average of the window as it stood before this sample
         dout <= acc[SW-1:depth];
         acc  <= acc_nxt;
         if (st == RUN) begin
            valid <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
               st <= RUN;
         end
      end
   end

endmodule

// File: tb/tb_jt49_boxcar.sv
// Self-checking bench for jt49_boxcar (DW=8, depth=2).
// Expected values come from a sample-history window model.
module tb_jt49_boxcar;

   localparam int DW    = 8;
   localparam int DEPTH = 2;
   localparam int N     = 1 << DEPTH;

   typedef struct {
      int acc;
      int dout;
      int valid;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cen = 1'b0;
   logic          clr = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dly = '0;
   logic [DW-1:0] dout;
   logic          valid;

   int   n_tot = 0;
   int   n_bad = 0;
   int   hist[$];
   exp_t sbq[$];
   exp_t last_e;
   int   prev_acc = 0;

   jt49_boxcar #(
      .DW   (DW),
      .depth(DEPTH)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .cen  (cen),
      .clr  (clr),
      .din  (din),
      .dly  (dly),
      .dout (dout),
      .valid(valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tot++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input exp_t e);
      chk({tag, ".acc"},   int'(dut.acc), e.acc);
      chk({tag, ".dout"},  int'(dout),    e.dout);
      chk({tag, ".valid"}, int'(valid),   e.valid);
   endtask

   task automatic fresh();
      hist.delete();
      prev_acc     = 0;
      last_e.acc   = 0;
      last_e.dout  = 0;
      last_e.valid = 0;
   endtask

   // One cen tick; dly follows an ideal delay line, garbage 255
   // while the line has not yet been filled.
   task automatic tick(input int d);
      int   k, s, dl;
      exp_t e;
      dl  = (hist.size() >= N) ? hist[hist.size()-N] : 255;
      din = DW'(d);
      dly = DW'(dl);
      cen = 1'b1;
      hist.push_back(d);
      k = hist.size();
      s = 0;
      for (int i = (k > N ? k - N : 0); i < k; i++)
         s += hist[i];
      e.acc   = s;
      e.dout  = prev_acc / N;
      e.valid = (k > N) ? 1 : 0;
      prev_acc = s;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      cen = 1'b0;
      if (sbq.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sbq.pop_front();
         cmp_all($sformatf("tick%0d", k), e);
         last_e = e;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cen = 1'b0;
         din = DW'($urandom_range(0, 255));
         dly = DW'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         cmp_all($sformatf("hold%0d", i), last_e);
      end
   endtask

   task automatic kill(input bit use_rst, input string tag);
      exp_t z;
      z.acc = 0; z.dout = 0; z.valid = 0;
      cen = 1'b1;
      din = DW'(50);
      dly = DW'(50);
      if (use_rst) rst = 1'b1;
      else clr = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr = 1'b0;
      cen = 1'b0;
      cmp_all(tag, z);
      chk({tag, ".st"}, int'(dut.st), 0);
      fresh();
   endtask

   initial begin
      fresh();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cmp_all("reset", last_e);

      // Constant 100: acc ramps to 400, dout settles at 100
      for (int i = 0; i < 8; i++) tick(100);

      // Hold with cen low while inputs toggle, then resume
      idle(10);
      tick(100);
      tick(100);

      // Clear with cen high wins
      kill(1'b0, "clr");

      // Fill masking (dly=255 during fill) with din=8
      for (int i = 0; i < 6; i++) tick(8);

      // Reset with cen high wins
      kill(1'b1, "rst");

      // Step: 8 zeros then 200
      for (int i = 0; i < 8; i++)  tick(0);
      for (int i = 0; i < 7; i++)  tick(200);

      // Max value steady
      kill(1'b0, "clr2");
      for (int i = 0; i < 8; i++) tick(255);

      // Random traffic through the window
      for (int i = 0; i < 40; i++) tick(int'($urandom_range(0, 255)));
      idle(3);
      for (int i = 0; i < 5; i++) tick(int'($urandom_range(0, 255)));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
